// File: rtl/window_reader_pkg.sv
// Shared types and size helpers for the 3x3 window reader.
// Optional coordinate outputs are enabled with WINDOW_READER_COORD_EN.
package window_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int TAPS = 9;

    function automatic int pad_w(input int w);
        return w + 2;
    endfunction

    function automatic int pad_h(input int h);
        return h + 2;
    endfunction

    function automatic int addr_w(input int w, input int h);
        return $clog2(pad_w(w) * pad_h(h));
    endfunction

    function automatic int tap_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/window_reader_if.sv
// Memory read port and window output handshake of the window reader.
// Coordinate signals exist only with WINDOW_READER_COORD_EN.
interface window_reader_if #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8
);
    import window_pkg::*;

    localparam int AW = addr_w(IMG_W, IMG_H);

    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [PIX_W-1:0]      rd_data;
    logic                  win_valid;
    logic                  win_ready;
    logic [TAPS*PIX_W-1:0] win_data;
`ifdef WINDOW_READER_COORD_EN
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    logic [RW-1:0]         win_row;
    logic [CW-1:0]         win_col;
`endif

    modport master (
        output rd_en, rd_addr, win_valid, win_data,
`ifdef WINDOW_READER_COORD_EN
        output win_row, win_col,
`endif
        input  rd_data, win_ready
    );

    modport slave (
        input  rd_en, rd_addr, win_valid, win_data,
`ifdef WINDOW_READER_COORD_EN
        input  win_row, win_col,
`endif
        output rd_data, win_ready
    );

endinterface

// File: rtl/window_reader_line_buffer.sv
// One padded image row; read and write share a wrapping column pointer
// that steps on adv, so rd_data is the value stored one row earlier.
module line_buffer #(
    parameter int DEPTH = 258,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] PTR_LAST = IW'(DEPTH - 1);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;

    assign rd_data = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (adv) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/window_reader.sv
// Streams the padded image in raster order and emits one 3x3 window per
// output pixel. WINDOW_READER_COORD_EN adds win_row/win_col outputs.
module window_reader
    import window_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    window_reader_if.master bus,
    output logic            busy,
    output logic            done
);
    localparam int PW   = pad_w(IMG_W);
    localparam int PH   = pad_h(IMG_H);
    localparam int NPIX = PW * PH;
    localparam int AW   = addr_w(IMG_W, IMG_H);
    localparam int XW   = $clog2(PW);
    localparam int YW   = $clog2(PH);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [XW-1:0] COL_LAST  = XW'(PW - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(PH - 1);

    state_t                      state_q, state_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic                        pend_q, pend_d;
    logic                        hold_full_q, hold_full_d;
    logic [PIX_W-1:0]            hold_q, hold_d;
    logic [XW-1:0]               col_q, col_d;
    logic [YW-1:0]               row_q, row_d;
    logic [TAPS-1:0][PIX_W-1:0]  tap_q, tap_d;
    logic                        win_valid_q, win_valid_d;
    logic                        win_last_q, win_last_d;
    logic [TAPS*PIX_W-1:0]       win_data_q, win_data_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
`ifdef WINDOW_READER_COORD_EN
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    logic [RW-1:0]               win_row_q, win_row_d;
    logic [CW-1:0]               win_col_q, win_col_d;
`endif

    logic             start;
    logic             stall;
    logic             rd_en;
    logic             out_free;
    logic             have_pix;
    logic             push;
    logic             emit;
    logic             pix_last;
    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    assign start    = (state_q == S_IDLE) & en;
    assign stall    = (win_valid_q & ~bus.win_ready) | hold_full_q;
    assign rd_en    = (state_q == S_RUN) & ~stall & ~rst;
    assign out_free = ~win_valid_q | bus.win_ready;
    // A held pixel is always older than any returning read.
    assign have_pix = hold_full_q | pend_q;
    assign pix      = hold_full_q ? hold_q : bus.rd_data;
    assign push     = have_pix & out_free;
    assign emit     = push & (row_q >= YW'(2)) & (col_q >= XW'(2));
    assign pix_last = (row_q == ROW_LAST) & (col_q == COL_LAST);

    line_buffer #(.DEPTH(PW), .PIX_W(PIX_W)) u_lb0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .adv     (push),
        .wr_data (pix),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(PW), .PIX_W(PIX_W)) u_lb1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .adv     (push),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pend_d      = rd_en;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        col_d       = col_q;
        row_d       = row_q;
        tap_d       = tap_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_data_d  = win_data_q;
`ifdef WINDOW_READER_COORD_EN
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
`endif

        unique case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (rd_en && addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: if (win_valid_q && bus.win_ready && win_last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            addr_d = '0;
            col_d  = '0;
            row_d  = '0;
        end else if (rd_en) begin
            addr_d = addr_q + 1'b1;
        end

        if (pend_q && !out_free) begin
            hold_full_d = 1'b1;
            hold_d      = bus.rd_data;
        end else if (hold_full_q && push) begin
            hold_full_d = 1'b0;
        end

        if (push) begin
            for (int r = 0; r < 3; r++) begin
                tap_d[tap_idx(r, 0)] = tap_q[tap_idx(r, 1)];
                tap_d[tap_idx(r, 1)] = tap_q[tap_idx(r, 2)];
            end
            tap_d[tap_idx(0, 2)] = lb1_rd;
            tap_d[tap_idx(1, 2)] = lb0_rd;
            tap_d[tap_idx(2, 2)] = pix;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (emit) begin
            win_valid_d = 1'b1;
            win_last_d  = pix_last;
            win_data_d  = tap_d;
`ifdef WINDOW_READER_COORD_EN
            win_row_d   = RW'(row_q - YW'(2));
            win_col_d   = CW'(col_q - XW'(2));
`endif
        end else if (out_free) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            tap_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef WINDOW_READER_COORD_EN
            win_row_q   <= '0;
            win_col_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tap_q       <= tap_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_data_q  <= win_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef WINDOW_READER_COORD_EN
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
`endif
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = addr_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
`ifdef WINDOW_READER_COORD_EN
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
`endif
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_window_reader.sv
// Bench for window_reader on a 4x3 image: memory model, window scoreboard
// built from the padded image, and several back-pressure patterns.
module tb_window_reader;
    import window_pkg::*;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int PIX_W  = 8;
    localparam int PW     = IMG_W + 2;
    localparam int PH     = IMG_H + 2;
    localparam int NPIX   = PW * PH;
    localparam int NWIN   = IMG_W * IMG_H;
    localparam int WB     = 9 * PIX_W;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    window_reader_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) bus ();

    window_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    logic [PIX_W-1:0] mem [NPIX];
    logic [WB-1:0]    exp_win [NWIN];

    int total = 0;
    int bad   = 0;
    int first_cyc, last_cyc, done_cyc;
    int n_win, n_done, stall_reads, exp_addr;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic chk(input string tag, input logic [WB-1:0] got,
                       input logic [WB-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Expected windows straight from the padded image: output (y,x) sees
    // padded rows y..y+2 and columns x..x+2.
    task automatic fill_mem(input bit ramp);
        for (int a = 0; a < NPIX; a++)
            mem[a] = ramp ? PIX_W'(a) : PIX_W'($urandom);
        for (int w = 0; w < NWIN; w++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_win[w][(3*r+c)*PIX_W +: PIX_W] =
                        mem[(w / IMG_W + r) * PW + (w % IMG_W) + c];
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return !(cyc >= 17 && cyc < 67);
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic run_frame(input int mode, input int rst_at, input int en_again);
        logic          prev_stall;
        logic [WB-1:0] held;
        logic          fin;
        prev_stall  = 1'b0;
        held        = '0;
        fin         = 1'b0;
        first_cyc   = -1;
        last_cyc    = -1;
        done_cyc    = -1;
        n_win       = 0;
        n_done      = 0;
        stall_reads = 0;
        exp_addr    = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            en = (cyc == 0) || (cyc == en_again);
            bus.win_ready = ready_for(mode, cyc);
            #1;
            if (prev_stall) begin
                chk("hold_valid", WB'(bus.win_valid), 1);
                chk("hold_data", bus.win_data, held);
            end
            if (cyc == 1) chk("busy_run", WB'(busy), 1);
            if (bus.rd_en) begin
                chk("rd_addr", WB'(bus.rd_addr), WB'(exp_addr));
                exp_addr++;
                if (mode == 2 && cyc >= 17 && cyc < 67) stall_reads++;
            end
            if (bus.win_valid && !bus.win_ready)
                chk("rd_en_stall", WB'(bus.rd_en), 0);
            if (bus.win_valid && first_cyc < 0) first_cyc = cyc;
            if (bus.win_valid && bus.win_ready) begin
                if (n_win < NWIN) begin
                    chk("win", bus.win_data, exp_win[n_win]);
`ifdef WINDOW_READER_COORD_EN
                    chk("win_row", WB'(bus.win_row), WB'(n_win / IMG_W));
                    chk("win_col", WB'(bus.win_col), WB'(n_win % IMG_W));
`endif
                end else begin
                    chk("extra_win", WB'(n_win), WB'(NWIN - 1));
                end
                n_win++;
                last_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1)
                chk("busy_idle", WB'(busy), 0);
            prev_stall = bus.win_valid && !bus.win_ready;
            held = bus.win_data;
            if (rst_at >= 0 && n_win == rst_at) begin
                en  = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_valid", WB'(bus.win_valid), 0);
                chk("rst_busy", WB'(busy), 0);
                chk("rst_rd_en", WB'(bus.rd_en), 0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    #1;
                    chk("rst_quiet", WB'({bus.rd_en, done}), 0);
                end
                return;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                fin = 1'b1;
                break;
            end
        end
        chk("frame_end", WB'(fin), 1);
    endtask

    initial begin
        bus.win_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rd_en0", WB'(bus.rd_en), 0);
        chk("rst_addr0", WB'(bus.rd_addr), 0);
        chk("rst_valid0", WB'(bus.win_valid), 0);
        chk("rst_data0", bus.win_data, 0);
        chk("rst_busy0", WB'(busy), 0);
        chk("rst_done0", WB'(done), 0);

        fill_mem(1'b1);
        run_frame(0, -1, -1);
        chk("first_cyc", WB'(first_cyc), WB'(3 + 2 * PW + 2));
        chk("n_win", WB'(n_win), WB'(NWIN));
        chk("last_cyc", WB'(last_cyc), WB'(2 + NPIX));
        chk("done_cyc", WB'(done_cyc), WB'(last_cyc + 1));
        chk("n_done", WB'(n_done), 1);
        chk("n_reads", WB'(exp_addr), WB'(NPIX));

        run_frame(1, -1, -1);
        chk("tog_n_win", WB'(n_win), WB'(NWIN));
        chk("tog_done", WB'(done_cyc), WB'(last_cyc + 1));
        chk("tog_n_done", WB'(n_done), 1);

        run_frame(2, -1, -1);
        chk("stall_reads_le2", WB'(stall_reads <= 2), 1);
        chk("stall_n_win", WB'(n_win), WB'(NWIN));
        chk("stall_n_done", WB'(n_done), 1);

        for (int f = 0; f < 3; f++) begin
            fill_mem(1'b0);
            run_frame(3, -1, -1);
            chk("rnd_n_win", WB'(n_win), WB'(NWIN));
            chk("rnd_n_done", WB'(n_done), 1);
            chk("rnd_reads", WB'(exp_addr), WB'(NPIX));
        end

        run_frame(0, 5, -1);
        chk("rst_n_done", WB'(n_done), 0);
        run_frame(0, -1, -1);
        chk("restart_first", WB'(first_cyc), WB'(3 + 2 * PW + 2));
        chk("restart_n_win", WB'(n_win), WB'(NWIN));

        run_frame(0, -1, 10);
        chk("en_busy_n_win", WB'(n_win), WB'(NWIN));
        chk("en_busy_done", WB'(done_cyc), WB'(3 + NPIX));
        chk("en_busy_n_done", WB'(n_done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
